// File: rtl/axi_pkg.sv
// Shared AXI codes and FSM state types for the AXI memory slave.
//   RESP_OKAY / RESP_SLVERR : B/R response encodings
//   BURST_INCR              : only supported burst type
//   SIZE_4B                 : only supported beat size (4 bytes)
//   w_state_e / r_state_e   : write and read channel FSM states
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_mem_array.sv
// Byte-enabled 32-bit register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
//   clk          : write clock
//   we/waddr     : write enable and word index
//   wdata/wstrb  : write data and byte enables
//   raddr/rdata  : async read word index and data
module axi_mem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3-style memory slave with independent, concurrent write and read FSMs
// backed by a DEPTH-word byte-enabled array.
//   aw*/w*/b*  : write address, data and response channels
//   ar*/r*     : read address and data channels
// Only 4-byte INCR bursts are supported; bursts that start out of range or
// use another size/type are answered with SLVERR and never touch memory.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [3:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [3:0]  wid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    input  logic [3:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [3:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [3:0]  rid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i
);

    localparam int unsigned AW = $clog2(DEPTH);

    w_state_e    w_state, w_next;
    r_state_e    r_state, r_next;

    logic [31:0] w_addr, r_addr, r_addr_nxt_c;
    logic [3:0]  w_len, w_beat, r_len, r_beat, r_beat_nxt_c;
    logic        w_err, w_perr, r_err;
    logic        aw_hs_c, w_hs_c, ar_hs_c, r_hs_c;
    logic        aw_err_c, ar_err_c;
    logic [AW-1:0] mem_raddr_c;
    logic [31:0]   mem_rdata_c;

    // Handshakes and burst legality checks
    assign aw_hs_c  = (w_state == W_IDLE) && awvalid_i;
    assign w_hs_c   = (w_state == W_DATA) && wvalid_i;
    assign ar_hs_c  = (r_state == R_IDLE) && arvalid_i;
    assign r_hs_c   = (r_state == R_DATA) && rready_i;
    assign aw_err_c = (awaddr_i[31:AW+2] != '0) || (awsize_i != SIZE_4B) || (awburst_i != BURST_INCR);
    assign ar_err_c = (araddr_i[31:AW+2] != '0) || (arsize_i != SIZE_4B) || (arburst_i != BURST_INCR);

    assign r_addr_nxt_c = r_addr + 32'd4;
    assign r_beat_nxt_c = 4'(r_beat + 4'd1);
    // Read port looks at the AR start address while idle, at the next beat otherwise
    assign mem_raddr_c  = (r_state == R_IDLE) ? araddr_i[2 +: AW] : r_addr_nxt_c[2 +: AW];

    axi_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_hs_c && !w_err),
        .waddr (w_addr[2 +: AW]),
        .wdata (wdata_i),
        .wstrb (wstrb_i),
        .raddr (mem_raddr_c),
        .rdata (mem_rdata_c)
    );

    // State registers; ready/valid flags are registered decodes of next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            awready_o <= 1'b1;
            wready_o  <= 1'b0;
            bvalid_o  <= 1'b0;
            arready_o <= 1'b1;
            rvalid_o  <= 1'b0;
        end else begin
            w_state   <= w_next;
            r_state   <= r_next;
            awready_o <= (w_next == W_IDLE);
            wready_o  <= (w_next == W_DATA);
            bvalid_o  <= (w_next == W_RESP);
            arready_o <= (r_next == R_IDLE);
            rvalid_o  <= (r_next == R_DATA);
        end
    end

    // Next-state logic for both channels
    always_comb begin
        w_next = w_state;
        r_next = r_state;
        unique case (w_state)
            W_IDLE:  if (awvalid_i)            w_next = W_DATA;
            W_DATA:  if (wvalid_i && wlast_i)  w_next = W_RESP;
            W_RESP:  if (bready_i)             w_next = W_IDLE;
            default:                           w_next = W_IDLE;
        endcase
        unique case (r_state)
            R_IDLE:  if (arvalid_i)            r_next = R_DATA;
            R_DATA:  if (rready_i && rlast_o)  r_next = R_IDLE;
            default:                           r_next = R_IDLE;
        endcase
    end

    // Write burst tracking and response generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_perr  <= 1'b0;
            bid_o   <= '0;
            bresp_o <= RESP_OKAY;
        end else begin
            if (aw_hs_c) begin
                w_addr <= awaddr_i;
                w_len  <= awlen_i;
                w_beat <= '0;
                w_err  <= aw_err_c;
                w_perr <= 1'b0;
                bid_o  <= awid_i;
            end
            if (w_hs_c) begin
                w_addr <= w_addr + 32'd4;
                w_beat <= 4'(w_beat + 4'd1);
                // Sticky: wlast early, or a beat passes awlen without wlast
                if (wlast_i != (w_beat == w_len)) begin
                    w_perr <= 1'b1;
                end
                if (wlast_i) begin
                    bresp_o <= (w_err || w_perr || (w_beat != w_len)) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Read burst tracking; R payload is registered so it holds under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
            rid_o   <= '0;
            rdata_o <= '0;
            rresp_o <= RESP_OKAY;
            rlast_o <= 1'b0;
        end else if (ar_hs_c) begin
            r_addr  <= araddr_i;
            r_len   <= arlen_i;
            r_beat  <= '0;
            r_err   <= ar_err_c;
            rid_o   <= arid_i;
            rdata_o <= ar_err_c ? 32'd0 : mem_rdata_c;
            rresp_o <= ar_err_c ? RESP_SLVERR : RESP_OKAY;
            rlast_o <= (arlen_i == 4'd0);
        end else if (r_hs_c) begin
            if (rlast_o) begin
                rdata_o <= '0;
                rresp_o <= RESP_OKAY;
                rlast_o <= 1'b0;
            end else begin
                r_addr  <= r_addr_nxt_c;
                r_beat  <= r_beat_nxt_c;
                rdata_o <= r_err ? 32'd0 : mem_rdata_c;
                rlast_o <= (r_beat_nxt_c == r_len);
            end
        end
    end

    // Byte-offset and above-range address bits carry no storage meaning
    logic unused_bits_c;
    assign unused_bits_c = ^{wid_i, w_addr[1:0], w_addr[31:AW+2],
                             r_addr_nxt_c[1:0], r_addr_nxt_c[31:AW+2]};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed, table-driven bench for axi_mem_slave (DEPTH = 1024).
module tb_axi_mem_slave;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid_i, wid_i, arid_i;
    logic [31:0] awaddr_i, araddr_i, wdata_i;
    logic [3:0]  awlen_i, arlen_i, wstrb_i;
    logic [2:0]  awsize_i, arsize_i;
    logic [1:0]  awburst_i, arburst_i;
    logic        awvalid_i, wlast_i, wvalid_i, bready_i, arvalid_i, rready_i;
    logic        awready_o, wready_o, bvalid_o, arready_o, rlast_o, rvalid_o;
    logic [3:0]  bid_o, rid_o;
    logic [1:0]  bresp_o, rresp_o;
    logic [31:0] rdata_o;

    int n_cmp = 0;
    int n_mis = 0;

    axi_mem_slave #(.DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] base;   // beat b carries base*(b+1) (write data or expected read data)
        logic [3:0]  strb;
        int          wl;     // beat index carrying wlast (writes only)
        logic [1:0]  resp;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: handshake did not occur within %0d cycles", name, TMO);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                            input logic [3:0] strb, input int wl, input logic [1:0] resp);
        int n;
        @(negedge clk);
        awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
        awvalid_i = 1'b1;
        n = 0;
        while (!awready_o && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) timeout("aw_wait");
        @(posedge clk);
        @(negedge clk);
        awvalid_i = 1'b0;
        for (int b = 0; b <= wl; b++) begin
            wid_i = id; wdata_i = 32'(base * 32'(b + 1)); wstrb_i = strb;
            wlast_i = (b == wl); wvalid_i = 1'b1;
            n = 0;
            while (!wready_o && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) timeout("w_wait");
            @(posedge clk);
            @(negedge clk);
        end
        wvalid_i = 1'b0; wlast_i = 1'b0;
        check("b_latency", 32'(bvalid_o), 32'd1);
        bready_i = 1'b1;
        n = 0;
        while (!bvalid_o && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) timeout("b_wait");
        check("bresp", 32'(bresp_o), 32'(resp));
        check("bid", 32'(bid_o), 32'(id));
        @(posedge clk);
        @(negedge clk);
        bready_i = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                           input logic [1:0] resp);
        int n;
        @(negedge clk);
        arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst;
        arvalid_i = 1'b1;
        n = 0;
        while (!arready_o && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) timeout("ar_wait");
        @(posedge clk);
        @(negedge clk);
        arvalid_i = 1'b0;
        rready_i  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == 0) check("r_first_latency", 32'(rvalid_o), 32'd1);
            n = 0;
            while (!rvalid_o && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) timeout("r_wait");
            check("rdata", rdata_o, 32'(base * 32'(b + 1)));
            check("rresp", 32'(rresp_o), 32'(resp));
            check("rlast", 32'(rlast_o), 32'(b == int'(len)));
            check("rid", 32'(rid_o), 32'(id));
            @(posedge clk);
            @(negedge clk);
        end
        rready_i = 1'b0;
        check("r_idle_after", 32'(rvalid_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        //          rd  id     addr           len   size    burst  base           strb  wl resp
        vt[0]  = '{1'b0, 4'h3, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 32'h11,        4'hF, 3, 2'b00};
        vt[1]  = '{1'b1, 4'h5, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 32'h11,        4'h0, 0, 2'b00};
        vt[2]  = '{1'b0, 4'h1, 32'h0000_0008, 4'd0, 3'b010, 2'b01, 32'h0,         4'hF, 0, 2'b00};
        vt[3]  = '{1'b0, 4'h2, 32'h0000_0008, 4'd0, 3'b010, 2'b01, 32'hAABBCCDD,  4'h5, 0, 2'b00};
        vt[4]  = '{1'b1, 4'h2, 32'h0000_0008, 4'd0, 3'b010, 2'b01, 32'h00BB00DD,  4'h0, 0, 2'b00};
        // Out-of-range (aliases word 0x40), wrap burst, and narrow size: no writes
        vt[5]  = '{1'b0, 4'h4, 32'h0000_1100, 4'd0, 3'b010, 2'b01, 32'hDEADBEEF,  4'hF, 0, 2'b10};
        vt[6]  = '{1'b0, 4'h6, 32'h0000_0100, 4'd1, 3'b010, 2'b10, 32'h99,        4'hF, 1, 2'b10};
        vt[7]  = '{1'b0, 4'h7, 32'h0000_0100, 4'd0, 3'b001, 2'b01, 32'h77,        4'hF, 0, 2'b10};
        vt[8]  = '{1'b1, 4'h8, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 32'h11,        4'h0, 0, 2'b00};
        vt[9]  = '{1'b1, 4'h9, 32'h0000_1100, 4'd1, 3'b010, 2'b01, 32'h0,         4'h0, 0, 2'b10};
        vt[10] = '{1'b1, 4'hA, 32'h0000_0100, 4'd2, 3'b010, 2'b10, 32'h0,         4'h0, 0, 2'b10};
        // wlast too early, then wlast too late
        vt[11] = '{1'b0, 4'hB, 32'h0000_0040, 4'd1, 3'b010, 2'b01, 32'h55,        4'hF, 0, 2'b10};
        vt[12] = '{1'b0, 4'hC, 32'h0000_0050, 4'd0, 3'b010, 2'b01, 32'h66,        4'hF, 1, 2'b10};
        // Top word then word index wraps to 0
        vt[13] = '{1'b0, 4'hD, 32'h0000_0FFC, 4'd1, 3'b010, 2'b01, 32'h70,        4'hF, 1, 2'b00};
        vt[14] = '{1'b1, 4'hE, 32'h0000_0FFC, 4'd1, 3'b010, 2'b01, 32'h70,        4'h0, 0, 2'b00};

        rst = 1'b1;
        awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
        wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
        arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
        rready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_awready", 32'(awready_o), 32'd1);
        check("rst_arready", 32'(arready_o), 32'd1);
        check("rst_wready",  32'(wready_o),  32'd0);
        check("rst_bvalid",  32'(bvalid_o),  32'd0);
        check("rst_rvalid",  32'(rvalid_o),  32'd0);
        check("rst_rlast",   32'(rlast_o),   32'd0);
        check("rst_rdata",   rdata_o,        32'd0);
        check("rst_bresp",   32'(bresp_o),   32'd0);

        foreach (vt[i]) begin
            if (vt[i].is_rd)
                do_read(vt[i].id, vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].base, vt[i].resp);
            else
                do_write(vt[i].id, vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].base,
                         vt[i].strb, vt[i].wl, vt[i].resp);
        end

        // Read backpressure: hold rready low for 5 cycles after beat 0
        @(negedge clk);
        arid_i = 4'h6; araddr_i = 32'h100; arlen_i = 4'd3; arsize_i = 3'b010; arburst_i = 2'b01;
        arvalid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arvalid_i = 1'b0;
        rready_i = 1'b1;
        check("stall_beat0", rdata_o, 32'h11);
        @(posedge clk);
        @(negedge clk);
        rready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("stall_rvalid", 32'(rvalid_o), 32'd1);
            check("stall_rdata", rdata_o, 32'h22);
            check("stall_rlast", 32'(rlast_o), 32'd0);
            @(negedge clk);
        end
        rready_i = 1'b1;
        for (int b = 1; b <= 3; b++) begin
            check("stall_resume_rdata", rdata_o, 32'(32'h11 * 32'(b + 1)));
            check("stall_resume_rlast", 32'(rlast_o), 32'(b == 3));
            @(posedge clk);
            @(negedge clk);
        end
        rready_i = 1'b0;
        check("stall_done", 32'(rvalid_o), 32'd0);

        // Same-cycle write and read of one word returns the old data
        do_write(4'h1, 32'h200, 4'd0, 3'b010, 2'b01, 32'h12345678, 4'hF, 0, 2'b00);
        @(negedge clk);
        awid_i = 4'h2; awaddr_i = 32'h200; awlen_i = 4'd0; awsize_i = 3'b010; awburst_i = 2'b01;
        awvalid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid_i = 1'b0;
        check("coll_wready", 32'(wready_o), 32'd1);
        wdata_i = 32'hCAFEF00D; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
        arid_i = 4'h3; araddr_i = 32'h200; arlen_i = 4'd0; arsize_i = 3'b010; arburst_i = 2'b01;
        arvalid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wvalid_i = 1'b0; wlast_i = 1'b0; arvalid_i = 1'b0;
        check("coll_rvalid", 32'(rvalid_o), 32'd1);
        check("coll_rdata_old", rdata_o, 32'h12345678);
        check("coll_bvalid", 32'(bvalid_o), 32'd1);
        rready_i = 1'b1; bready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready_i = 1'b0; bready_i = 1'b0;
        do_read(4'h4, 32'h200, 4'd0, 3'b010, 2'b01, 32'hCAFEF00D, 2'b00);

        // Reset during write beat 2 aborts the burst
        @(negedge clk);
        awid_i = 4'h9; awaddr_i = 32'h300; awlen_i = 4'd3; awsize_i = 3'b010; awburst_i = 2'b01;
        awvalid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wdata_i = 32'hA0 + 32'(b); wstrb_i = 4'hF; wlast_i = 1'b0; wvalid_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        wdata_i = 32'hA2;
        rst = 1'b1;
        @(negedge clk);
        wvalid_i = 1'b0;
        check("rst_mid_bvalid", 32'(bvalid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bvalid_o) n++;
        end
        check("rst_mid_no_bvalid", 32'(n), 32'd0);
        check("rst_mid_awready", 32'(awready_o), 32'd1);
        check("rst_mid_wready", 32'(wready_o), 32'd0);
        do_write(4'h5, 32'h300, 4'd1, 3'b010, 2'b01, 32'h77, 4'hF, 1, 2'b00);
        do_read(4'h5, 32'h300, 4'd1, 3'b010, 2'b01, 32'h77, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
